// File: rtl/rect_plotter_if.sv
// Fill-request and pixel-port bundle between the pong controller, rect_plotter and the VGA adapter.
interface rect_plotter_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic       clr_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour, clr_req,
    input  req_ready, x, y, colour, plot, busy, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour, clr_req,
    output req_ready, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_plotter.sv
// Clipped rectangle rasteriser: one pixel write per clock in raster order, then a done pulse.
// Define RECT_PLOT_CLEAR_EN to accept clr_req as a full-screen black fill.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic           clk,
  input logic           rst,
  rect_plotter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_t;

  state_t     state_reg;
  logic [8:0] xs_reg, xe_reg, ye_reg;

  logic       start;
  logic       empty_next;
  logic [8:0] x_sum, y_sum;
  logic [8:0] xs_next, xe_next, ys_next, ye_next;
  logic [2:0] colour_next;
  logic       x_wrap, y_last;

  // Bounds are kept 9 bits wide so an off-screen start can never wrap onto the screen.
  always_comb begin
    x_sum       = {1'b0, bus.req_x} + {1'b0, bus.req_w};
    y_sum       = {2'b0, bus.req_y} + {2'b0, bus.req_h};
    start       = bus.req_valid;
    xs_next     = {1'b0, bus.req_x};
    ys_next     = {2'b0, bus.req_y};
    xe_next     = (x_sum > 9'(SCREEN_W)) ? 9'(SCREEN_W) : x_sum;
    ye_next     = (y_sum > 9'(SCREEN_H)) ? 9'(SCREEN_H) : y_sum;
    colour_next = bus.req_colour;
`ifdef RECT_PLOT_CLEAR_EN
    if (bus.clr_req) begin
      start       = 1'b1;
      xs_next     = 9'd0;
      ys_next     = 9'd0;
      xe_next     = 9'(SCREEN_W);
      ye_next     = 9'(SCREEN_H);
      colour_next = 3'b000;
    end
`endif
    empty_next = (xs_next >= xe_next) || (ys_next >= ye_next);
  end

`ifndef RECT_PLOT_CLEAR_EN
  logic unused_clr;
  assign unused_clr = bus.clr_req;
`endif

  assign x_wrap = ({1'b0, bus.x} + 9'd1) == xe_reg;
  assign y_last = ({2'b0, bus.y} + 9'd1) == ye_reg;

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);

  // The x/y output registers double as the raster cursor.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.done   <= 1'b0;
      xs_reg     <= '0;
      xe_reg     <= '0;
      ye_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bus.plot <= 1'b0;
          bus.done <= 1'b0;
          if (start) begin
            if (empty_next) begin
              state_reg <= DONE;
              bus.done  <= 1'b1;
            end else begin
              state_reg  <= DRAW;
              bus.x      <= xs_next[7:0];
              bus.y      <= ys_next[6:0];
              bus.colour <= colour_next;
              bus.plot   <= 1'b1;
              xs_reg     <= xs_next;
              xe_reg     <= xe_next;
              ye_reg     <= ye_next;
            end
          end
        end
        DRAW: begin
          if (x_wrap) begin
            if (y_last) begin
              state_reg <= DONE;
              bus.plot  <= 1'b0;
              bus.done  <= 1'b1;
            end else begin
              bus.x <= xs_reg[7:0];
              bus.y <= bus.y + 7'd1;
            end
          end else begin
            bus.x <= bus.x + 8'd1;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rect_plotter.md
# rect_plotter

Rectangle rasteriser between the pong game controller and the 160x120 VGA frame-buffer adapter. The controller issues one fill request per paddle or ball, either to draw it or to erase it in black. The block steps through every on-screen pixel of the rectangle in raster order and emits one x/y/colour/plot write per clock on the adapter's pixel port. Off-screen parts of a rectangle are clipped. A done pulse tells the controller FSM that it may advance.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels; x range 0..SCREEN_W-1
- SCREEN_H, 120, visible height in pixels; y range 0..SCREEN_H-1

Ports:
- clk  in  1  system clock; the same clock that drives the VGA adapter
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  fill request present
- req_ready  out  1  high only in IDLE (combinational from state)
- req_x  in  8  left column
- req_y  in  7  top row
- req_w  in  8  width in pixels, 0 allowed
- req_h  in  7  height in pixels, 0 allowed
- req_colour  in  3  {R,G,B}, 1 bit per channel
- clr_req  in  1  full-screen clear request; only active with RECT_PLOT_CLEAR_EN
- x  out  8  pixel column to adapter
- y  out  7  pixel row to adapter
- colour  out  3  pixel colour to adapter
- plot  out  1  write strobe to adapter
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle pulse when a request completes

## Operation
- States: IDLE, DRAW, DONE. Reset (rst=0 at a clk edge) sets state IDLE and x=0, y=0, colour=0, plot=0, busy=0, done=0. req_ready=1 after reset.
- Accept happens in IDLE when req_valid=1. The block latches req_colour and computes clipped bounds in 9 bits:
  - xs=req_x, xe=min(req_x+req_w, SCREEN_W)
  - ys=req_y, ye=min(req_y+req_h, SCREEN_H)
- The request is empty if xs>=xe or ys>=ye. This covers w=0, h=0, req_x>=SCREEN_W and req_y>=SCREEN_H.
  - Empty: IDLE->DONE.
  - Not empty: IDLE->DRAW, with the cursor set to (xs,ys).
- DRAW:
  - Each cycle: x/y=cursor, plot=1, colour=latched colour.
  - The cursor advances x first. When x+1==xe, x wraps to xs and y increments.
  - After the pixel (xe-1, ye-1) is emitted, DRAW->DONE.
- DONE: plot=0, done=1 for exactly one cycle, then DONE->IDLE.
- In IDLE and DONE, plot=0 and x/y/colour hold their last values.
- Requests arriving while req_ready=0 are ignored. The controller must hold req_valid until it is accepted.
- Reset mid-DRAW abandons the rectangle. No done pulse is emitted, and pixels already written stay in the frame buffer.
- Arithmetic rule: no cursor register may wrap. Clipping bounds are compared in 9 bits, so req_x=200, req_w=100 is empty rather than wrapping to x=44.

## Timing
- Accept at edge N. The first pixel (plot=1) is valid in cycle N+1.
- A rectangle of P=(xe-xs)*(ye-ys) pixels occupies cycles N+1..N+P. done=1 in cycle N+P+1, and the state is IDLE in cycle N+P+2.
- An empty request gives done in cycle N+1.
- Peak throughput is one pixel per clock. Back-to-back requests have P+2 cycles between accepts.
- Outputs x, y, colour, plot and done are registered. req_ready and busy decode the state.

## Configuration
- RECT_PLOT_CLEAR_EN defined:
  - In IDLE, clr_req=1 is accepted with priority over req_valid.
  - It is treated as the request (0,0,SCREEN_W,SCREEN_H,colour=3'b000): 19200 pixels, then the normal done pulse.
- Undefined: clr_req is ignored. The port is kept so top-level wiring is unchanged.

## Test plan
- Reset, then a request (10,20,w=2,h=3,colour=3'b111) -> 6 plot cycles starting the cycle after accept, in the order (10,20),(11,20),(10,21),(11,21),(10,22),(11,22); done in the 7th cycle after accept; busy=1 throughout.
- Request (158,118,w=4,h=4) -> only (158,118),(159,118),(158,119),(159,119) plotted; done in the 5th cycle after accept.
- Requests with w=0, then with req_x=200/w=100 -> plot never asserts; done one cycle after each accept.
- req_valid held high across a 4x1 draw with the next request already present -> the second accept lands exactly 6 cycles after the first; no request is lost or duplicated.
- rst=0 for one cycle during the 3rd pixel of a 5x5 draw -> next cycle plot=0, busy=0, done=0, x=0, y=0, req_ready=1; no done pulse follows.
- With RECT_PLOT_CLEAR_EN, clr_req and req_valid both high in IDLE -> clear wins; 19200 black pixels ending at (159,119), then done. Without the macro, the same stimulus runs the req_* rectangle only.
